// File: rtl/pe_ws.sv
// Weight-stationary PE with double-buffered weight, runtime signed/unsigned MAC.
// Optional accumulate saturation enabled by defining PE_SAT_EN (default: wrap).
module pe_ws #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] in_up_weight,
  input  logic              in_up_wvld,
  output logic [DATA_W-1:0] out_down_weight,
  output logic              out_down_wvld,
  input  logic [DATA_W-1:0] in_left_act,
  input  logic              in_left_avld,
  input  logic              in_left_swap,
  output logic [DATA_W-1:0] out_right_act,
  output logic              out_right_avld,
  output logic              out_right_swap,
  input  logic [ACC_W-1:0]  in_up_psum,
  output logic [ACC_W-1:0]  out_down_psum,
  output logic              out_down_pvld,
  output logic              out_sat
);

  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [DATA_W-1:0]   downWeight_q, downWeight_d;
  logic                downWvld_q, downWvld_d;
  logic [DATA_W-1:0]   rightAct_q, rightAct_d;
  logic                rightAvld_q, rightAvld_d;
  logic                rightSwap_q, rightSwap_d;
  logic [ACC_W-1:0]    psum_q, psum_d;
  logic                pvld_q, pvld_d;
  logic                sat_d;

  logic [DATA_W-1:0]   wEff;
  logic signed [2*DATA_W-1:0] prodS;
  logic [2*DATA_W-1:0] prodU;
  logic [ACC_W-1:0]    prodExt;
  logic [ACC_W-1:0]    macResult;
  logic                macSat;

  // A swap in this cycle makes the multiply use the shadow weight immediately.
  assign wEff    = in_left_swap ? shadow_q : active_q;
  assign prodS   = $signed(wEff) * $signed(in_left_act);
  assign prodU   = {{DATA_W{1'b0}}, wEff} * {{DATA_W{1'b0}}, in_left_act};
  assign prodExt = signed_mode ? ACC_W'(prodS) : ACC_W'(prodU);

`ifdef PE_SAT_EN
  logic [ACC_W:0] sumWide;
  logic           signedOvf;
  assign sumWide   = {1'b0, in_up_psum} + {1'b0, prodExt};
  assign signedOvf = (in_up_psum[ACC_W-1] == prodExt[ACC_W-1]) &&
                     (sumWide[ACC_W-1] != in_up_psum[ACC_W-1]);

  // Signed overflow clamps toward the sign of the addends; unsigned only overflows upward.
  always_comb begin
    macResult = sumWide[ACC_W-1:0];
    macSat    = 1'b0;
    if (signed_mode) begin
      if (signedOvf) begin
        macResult = in_up_psum[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        macSat    = 1'b1;
      end
    end else if (sumWide[ACC_W]) begin
      macResult = {ACC_W{1'b1}};
      macSat    = 1'b1;
    end
  end
`else
  assign macResult = in_up_psum + prodExt;
  assign macSat    = 1'b0;
`endif

  always_comb begin
    shadow_d     = in_up_wvld ? in_up_weight : shadow_q;
    active_d     = in_left_swap ? shadow_q : active_q;
    downWeight_d = in_up_wvld ? shadow_q : '0;
    downWvld_d   = in_up_wvld;
    rightAct_d   = in_left_avld ? in_left_act : '0;
    rightAvld_d  = in_left_avld;
    rightSwap_d  = in_left_swap;
    psum_d       = in_left_avld ? macResult : '0;
    pvld_d       = in_left_avld;
    sat_d        = in_left_avld & macSat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q     <= '0;
      active_q     <= '0;
      downWeight_q <= '0;
      downWvld_q   <= 1'b0;
      rightAct_q   <= '0;
      rightAvld_q  <= 1'b0;
      rightSwap_q  <= 1'b0;
      psum_q       <= '0;
      pvld_q       <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      downWeight_q <= downWeight_d;
      downWvld_q   <= downWvld_d;
      rightAct_q   <= rightAct_d;
      rightAvld_q  <= rightAvld_d;
      rightSwap_q  <= rightSwap_d;
      psum_q       <= psum_d;
      pvld_q       <= pvld_d;
    end
  end

`ifdef PE_SAT_EN
  logic sat_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_q <= 1'b0;
    else      sat_q <= sat_d;
  end
  assign out_sat = sat_q;
`else
  logic unusedSat;
  assign unusedSat = sat_d;
  assign out_sat   = 1'b0;
`endif

  assign out_down_weight = downWeight_q;
  assign out_down_wvld   = downWvld_q;
  assign out_right_act   = rightAct_q;
  assign out_right_avld  = rightAvld_q;
  assign out_right_swap  = rightSwap_q;
  assign out_down_psum   = psum_q;
  assign out_down_pvld   = pvld_q;

endmodule

// File: tb/tb_pe_ws.sv
// Self-checking bench for pe_ws: directed steps then random cycles vs. an arithmetic model.
// Honours PE_SAT_EN the same way the design does (clamp vs. wrap).
module tb_pe_ws;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          signedMode;
  logic [DW-1:0] upWeight;
  logic          upWvld;
  logic [DW-1:0] downWeight;
  logic          downWvld;
  logic [DW-1:0] leftAct;
  logic          leftAvld;
  logic          leftSwap;
  logic [DW-1:0] rightAct;
  logic          rightAvld;
  logic          rightSwap;
  logic [AW-1:0] upPsum;
  logic [AW-1:0] downPsum;
  logic          downPvld;
  logic          sat;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [DW-1:0] mShadow, mActive;
  logic [DW-1:0] eDownWeight, eRightAct;
  logic          eDownWvld, eRightAvld, eRightSwap, ePvld, eSat;
  logic [AW-1:0] ePsum;

  pe_ws #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .signed_mode(signedMode),
    .in_up_weight(upWeight), .in_up_wvld(upWvld),
    .out_down_weight(downWeight), .out_down_wvld(downWvld),
    .in_left_act(leftAct), .in_left_avld(leftAvld), .in_left_swap(leftSwap),
    .out_right_act(rightAct), .out_right_avld(rightAvld), .out_right_swap(rightSwap),
    .in_up_psum(upPsum), .out_down_psum(downPsum), .out_down_pvld(downPvld),
    .out_sat(sat)
  );

  always #5 clk = ~clk;

  // True mathematical sum, then either wrapped modulo 2^AW or clamped to range.
  function automatic void modelMac(input logic sm, input logic [DW-1:0] w, input logic [DW-1:0] a,
                                   input logic [AW-1:0] pin, output logic [AW-1:0] res,
                                   output logic satOut);
    longint p, s, lo, hi;
    if (sm) begin
      p  = longint'($signed(w)) * longint'($signed(a));
      s  = longint'($signed(pin)) + p;
      lo = -(longint'(1) <<< (AW - 1));
      hi = (longint'(1) <<< (AW - 1)) - 1;
    end else begin
      p  = longint'(w) * longint'(a);
      s  = longint'(pin) + p;
      lo = 0;
      hi = (longint'(1) <<< AW) - 1;
    end
    res    = s[AW-1:0];
    satOut = 1'b0;
`ifdef PE_SAT_EN
    if (s > hi) begin
      res = hi[AW-1:0]; satOut = 1'b1;
    end else if (s < lo) begin
      res = lo[AW-1:0]; satOut = 1'b1;
    end
`endif
  endfunction

  task automatic applyStimulus(input logic wvld, input logic [DW-1:0] w, input logic avld,
                               input logic [DW-1:0] act, input logic swap, input logic sm,
                               input logic [AW-1:0] pin);
    logic [DW-1:0] wEff;
    logic [AW-1:0] r;
    logic          s;
    @(negedge clk);
    upWvld = wvld; upWeight = w; leftAvld = avld; leftAct = act;
    leftSwap = swap; signedMode = sm; upPsum = pin;
    wEff        = swap ? mShadow : mActive;
    eDownWeight = wvld ? mShadow : '0;
    eDownWvld   = wvld;
    eRightAct   = avld ? act : '0;
    eRightAvld  = avld;
    eRightSwap  = swap;
    modelMac(sm, wEff, act, pin, r, s);
    ePsum = avld ? r : '0;
    ePvld = avld;
    eSat  = avld & s;
    if (swap) mActive = mShadow;
    if (wvld) mShadow = w;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".psum"},  32'(downPsum),   32'(ePsum));
    checkOutput({tag, ".pvld"},  32'(downPvld),   32'(ePvld));
    checkOutput({tag, ".sat"},   32'(sat),        32'(eSat));
    checkOutput({tag, ".downW"}, 32'(downWeight), 32'(eDownWeight));
    checkOutput({tag, ".wvld"},  32'(downWvld),   32'(eDownWvld));
    checkOutput({tag, ".ract"},  32'(rightAct),   32'(eRightAct));
    checkOutput({tag, ".ravld"}, 32'(rightAvld),  32'(eRightAvld));
    checkOutput({tag, ".rswap"}, 32'(rightSwap),  32'(eRightSwap));
  endtask

  task automatic modelReset();
    mShadow = '0; mActive = '0;
    eDownWeight = '0; eDownWvld = 1'b0; eRightAct = '0; eRightAvld = 1'b0;
    eRightSwap = 1'b0; ePsum = '0; ePvld = 1'b0; eSat = 1'b0;
  endtask

  initial begin
    rst = 1'b0; signedMode = 1'b0; upWeight = '0; upWvld = 1'b0;
    leftAct = '0; leftAvld = 1'b0; leftSwap = 1'b0; upPsum = '0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b1;

    // Unsigned load 5 then 7, then compute through the swap.
    applyStimulus(1, 8'd5, 0, 8'd0, 0, 0, 16'd0);  checkAll("load5");
    applyStimulus(1, 8'd7, 0, 8'd0, 0, 0, 16'd0);  checkAll("load7");
    applyStimulus(0, 8'd0, 1, 8'd3, 1, 0, 16'd10); checkAll("mac31");
    applyStimulus(0, 8'd0, 1, 8'd2, 0, 0, 16'd10); checkAll("mac24");
    applyStimulus(0, 8'd0, 1, 8'd3, 0, 0, 16'd10); checkAll("mac31b");

    // Asynchronous reset between edges.
    #2 rst = 1'b0;
    modelReset();
    #1 checkAll("asyncRst");
    rst = 1'b1;
    applyStimulus(1, 8'd4, 1, 8'd1, 0, 0, 16'd0);  checkAll("postRst");

    // Signedness of the same bit patterns.
    applyStimulus(1, 8'hFF, 0, 8'd0, 0, 0, 16'd0);  checkAll("loadFF");
    applyStimulus(0, 8'd0, 1, 8'h80, 1, 1, 16'd0);  checkAll("signed");
    applyStimulus(0, 8'd0, 1, 8'h80, 0, 0, 16'd0);  checkAll("unsigned");

    // Simultaneous load and swap.
    applyStimulus(1, 8'd2, 0, 8'd0, 0, 0, 16'd0);  checkAll("ld2");
    applyStimulus(1, 8'd4, 0, 8'd0, 1, 0, 16'd0);  checkAll("sw2ld4");
    applyStimulus(1, 8'd9, 1, 8'd1, 1, 0, 16'd0);  checkAll("ldSwap");
    applyStimulus(1, 8'd0, 0, 8'd0, 0, 0, 16'd0);  checkAll("shadow9");

    // Signed overflow at the accumulator top.
    applyStimulus(1, 8'd1, 0, 8'd0, 1, 1, 16'd0);    checkAll("ld1");
    applyStimulus(0, 8'd0, 0, 8'd0, 1, 1, 16'd0);    checkAll("sw1");
    applyStimulus(0, 8'd0, 1, 8'd1, 0, 1, 16'h7FFF); checkAll("ovfPos");
    applyStimulus(0, 8'd0, 1, 8'hFF, 0, 1, 16'h8000); checkAll("ovfNeg");
    applyStimulus(0, 8'd0, 1, 8'hFF, 0, 0, 16'hFFFF); checkAll("ovfU");

    // Bubble with swap: forwarded swap, no result, active still updated.
    applyStimulus(1, 8'd6, 0, 8'd0, 0, 0, 16'd0);   checkAll("ld6");
    applyStimulus(0, 8'd0, 0, 8'h55, 1, 0, 16'd0);  checkAll("bubble");
    applyStimulus(0, 8'd0, 1, 8'd1, 0, 0, 16'd0);   checkAll("afterBub");

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                    1'($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom));
      checkAll("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pe_ws.md
# pe_ws

Parametrised weight-stationary processing element, the next-generation tile of the systolic array. Adds configurable data/accumulator widths and a double-buffered weight: a shadow register loads the next tile's weights down the column while the active weight keeps computing. Valid and swap strobes travel with the data wavefront. Signed/unsigned operand mode is selected at runtime. Instances are tiled into an R×C grid:
- activations flow left→right;
- weights and partial sums flow top→bottom.

## Interface
- `DATA_W`, 8, weight/activation width.
- `ACC_W`, 32, partial-sum width; must be ≥ 2·`DATA_W`.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `signed_mode`  in  1  1: operands two's complement; 0: unsigned.
- `in_up_weight`  in  `DATA_W`  weight shifting down the column.
- `in_up_wvld`  in  1  `in_up_weight` valid (load strobe).
- `out_down_weight`  out  `DATA_W`  weight forwarded to PE below.
- `out_down_wvld`  out  1  forwarded load strobe.
- `in_left_act`  in  `DATA_W`  activation.
- `in_left_avld`  in  1  activation valid.
- `in_left_swap`  in  1  swap strobe, aligned with activation wavefront.
- `out_right_act`  out  `DATA_W`  forwarded activation.
- `out_right_avld`  out  1  forwarded activation valid.
- `out_right_swap`  out  1  forwarded swap strobe.
- `in_up_psum`  in  `ACC_W`  incoming partial sum (top row ties 0).
- `out_down_psum`  out  `ACC_W`  outgoing partial sum.
- `out_down_pvld`  out  1  `out_down_psum` valid.
- `out_sat`  out  1  saturation occurred this result (see Configuration).

## Operation
- State:
  - `shadow` (`DATA_W`), `active` (`DATA_W`), plus registered copies of every output.
- Weight load (column shift register):
  - When `in_up_wvld`=1: `shadow` ← `in_up_weight`; `out_down_weight` ← old `shadow`; `out_down_wvld` ← 1.
  - When `in_up_wvld`=0: `out_down_weight` ← 0; `out_down_wvld` ← 0; `shadow` holds.
  - Loading an R-row column takes R cycles. Push the bottom row's weight first.
- Swap:
  - When `in_left_swap`=1: `active` ← `shadow`.
  - The multiply in that same cycle uses the new weight: w_eff = `in_left_swap` ? `shadow` : `active`.
  - The swap applies and is forwarded regardless of `in_left_avld`.
- Load and swap in the same cycle: w_eff and `active` take the old `shadow`; `shadow` takes `in_up_weight`.
- MAC:
  - When `in_left_avld`=1: `out_down_psum` ← `in_up_psum` + ext(w_eff × `in_left_act`); `out_down_pvld` ← 1.
  - When `in_left_avld`=0: `out_down_psum` ← 0; `out_down_pvld` ← 0.
- Width rules:
  - The product is 2·`DATA_W` bits, computed signed or unsigned per `signed_mode`.
  - ext() sign-extends (signed) or zero-extends (unsigned) the product to `ACC_W`.
  - The add is `ACC_W` bits; overflow wraps unless `PE_SAT_EN`.
- Forwarding:
  - `out_right_act` ← `in_left_act` when `in_left_avld`, else 0.
  - `out_right_avld` ← `in_left_avld`.
  - `out_right_swap` ← `in_left_swap`.

## Timing
- Every output is registered; latency is exactly 1 cycle from input to the corresponding output.
- No backpressure: the array is free-running, and upstream sequencing guarantees strobes.
- Reset (`rst`=0):
  - Immediately, without a clock edge, clears `shadow`, `active` and all outputs to 0.
  - Applies mid-load or mid-compute; any partially loaded tile is lost.
  - First update occurs on the first rising `clk` after `rst`=1.
- `signed_mode` is sampled each cycle together with `in_left_avld`. Changing it between tiles is legal.

## Configuration
- `PE_SAT_EN` defined: the accumulate saturates instead of wrapping.
  - signed_mode=1: clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - signed_mode=0: clamps to [0, 2^ACC_W−1].
  - `out_sat` ← 1 for a clamped valid result, else 0.
- `PE_SAT_EN` undefined:
  - Modulo-2^ACC_W wrap; `out_sat` constantly 0.

## Test plan
- Async reset: hold `shadow`=7, psum output 31; drive `rst`=0 between edges → all outputs 0 before the next edge; `active`, `shadow` = 0.
- Load and compute, unsigned: load 5 then 7 over 2 cycles → `out_down_weight`=5 in the 2nd output cycle. Then act=3, swap=1, psum_in=10 → psum 31. Next act=2, swap=0 → 24.
- Signedness: w=0xFF, act=0x80, psum_in=0:
  - signed_mode=1 → 128.
  - signed_mode=0 → 32640.
- Simultaneous load and swap: active=2, shadow=4; `in_up_weight`=9 with wvld, swap=1, act=1 → psum 4, `shadow`=9, `out_down_weight`=4.
- Overflow (ACC_W=16, signed): psum_in=0x7FFF, w=1, act=1.
  - With `PE_SAT_EN` → 0x7FFF, `out_sat`=1.
  - Without → 0x8000, `out_sat`=0.
- Bubble: avld=0, swap=1, act=0x55 → psum 0, pvld 0, `out_right_act`=0, `out_right_swap`=1, `active` updated.
